// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: command opcodes, decoder states and default panel size.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned LCD_H_RES = 240;
    localparam int unsigned LCD_V_RES = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_RASET = 2'd2,
        ST_RAMWR = 2'd3
    } dec_state_e;

endpackage

// File: rtl/lcd_spi_deser.sv
// Synchronises the snooped 4-wire LCD bus and turns SCL-qualified SDA bits into bytes.
module lcd_spi_deser #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl_i,
    input  logic       cs_i,
    input  logic       rs_i,
    input  logic       sda_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_is_data_o
);

    localparam int unsigned CNT_W = 3;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;

    logic             scl_s, cs_s, rs_s, sda_s, scl_rise;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             rs_q, rs_d;

    logic       byte_valid_q;
    logic [7:0] byte_data_q;
    logic       byte_is_data_q;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign rs_s     = rs_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;

    // Shift on each qualified SCL rise; a raised CS drops any partial byte.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        rs_d    = rs_q;
        if (cs_s) begin
            cnt_d = '0;
        end else if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
                done_d = 1'b1;
                rs_d   = rs_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_sync_q     <= '0;
            cs_sync_q      <= '1;
            rs_sync_q      <= '0;
            sda_sync_q     <= '0;
            scl_prev_q     <= 1'b0;
            shift_q        <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            rs_q           <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= '0;
            byte_is_data_q <= 1'b0;
        end else begin
            scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            rs_sync_q    <= {rs_sync_q[SYNC_STAGES-2:0], rs_i};
            sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q   <= scl_s;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            rs_q         <= rs_d;
            byte_valid_q <= done_q;
            if (done_q) begin
                byte_data_q    <= shift_q;
                byte_is_data_q <= rs_q;
            end
        end
    end

    assign byte_valid_o   = byte_valid_q;
    assign byte_data_o    = byte_data_q;
    assign byte_is_data_o = byte_is_data_q;

endmodule

// File: rtl/lcd_spi_monitor.sv
// Passive LCD bus monitor: decodes CASET/RASET/RAMWR and rebuilds RGB565 pixels with coordinates.
module lcd_spi_monitor
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COORD_W     = 9,
    parameter int unsigned H_RES       = LCD_H_RES,
    parameter int unsigned V_RES       = LCD_V_RES
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               lcd_clk_i,
    input  logic               lcd_cs_i,
    input  logic               lcd_rs_i,
    input  logic               lcd_data_i,
    output logic               byte_valid,
    output logic [7:0]         byte_data,
    output logic               byte_is_data,
    output logic               pix_valid,
    output logic [15:0]        pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_done,
    output logic               ramwr_active
);

    localparam logic [COORD_W-1:0] XE_RST = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] YE_RST = COORD_W'(V_RES - 1);

    lcd_spi_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk            (clk),
        .resetn         (resetn),
        .scl_i          (lcd_clk_i),
        .cs_i           (lcd_cs_i),
        .rs_i           (lcd_rs_i),
        .sda_i          (lcd_data_i),
        .byte_valid_o   (byte_valid),
        .byte_data_o    (byte_data),
        .byte_is_data_o (byte_is_data)
    );

    dec_state_e         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [23:0]        par_q, par_d;
    logic               phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

    logic               pix_valid_q, pix_valid_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic               frame_done_q, frame_done_d;
    logic               ramwr_active_q;

    logic [15:0]        start_raw, end_raw;
    logic [COORD_W-1:0] start_val, end_val, xe_eff, ye_eff;

    assign start_raw = par_q[23:8];
    assign end_raw   = {par_q[7:0], byte_data};
    assign start_val = COORD_W'(start_raw);
    assign end_val   = COORD_W'(end_raw);

    // An inverted window collapses to a single column/row at its start.
    assign xe_eff = (xe_q < xs_q) ? xs_q : xe_q;
    assign ye_eff = (ye_q < ys_q) ? ys_q : ye_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        par_d        = par_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_done_d = 1'b0;

        if (byte_valid) begin
            if (!byte_is_data) begin
                idx_d   = '0;
                phase_d = 1'b0;
                case (byte_data)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        if (idx_q == 2'd3) begin
                            if (state_q == ST_CASET) begin
                                xs_d = start_val;
                                xe_d = end_val;
                            end else begin
                                ys_d = start_val;
                                ye_d = end_val;
                            end
                            idx_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            par_d = {par_q[15:0], byte_data};
                            idx_d = idx_q + 2'd1;
                        end
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            hi_d    = byte_data;
                            phase_d = 1'b1;
                        end else begin
                            phase_d     = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_data_d  = {hi_q, byte_data};
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                            if (x_q == xe_eff) begin
                                x_d = xs_q;
                                if (y_q == ye_eff) begin
                                    y_d          = ys_q;
                                    frame_done_d = 1'b1;
                                end else begin
                                    y_d = y_q + COORD_W'(1);
                                end
                            end else begin
                                x_d = x_q + COORD_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            par_q          <= '0;
            phase_q        <= 1'b0;
            hi_q           <= '0;
            xs_q           <= '0;
            xe_q           <= XE_RST;
            ys_q           <= '0;
            ye_q           <= YE_RST;
            x_q            <= '0;
            y_q            <= '0;
            pix_valid_q    <= 1'b0;
            pix_data_q     <= '0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            frame_done_q   <= 1'b0;
            ramwr_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            par_q          <= par_d;
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            xs_q           <= xs_d;
            xe_q           <= xe_d;
            ys_q           <= ys_d;
            ye_q           <= ye_d;
            x_q            <= x_d;
            y_q            <= y_d;
            pix_valid_q    <= pix_valid_d;
            pix_data_q     <= pix_data_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            frame_done_q   <= frame_done_d;
            ramwr_active_q <= (state_d == ST_RAMWR);
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign frame_done   = frame_done_q;
    assign ramwr_active = ramwr_active_q;

endmodule

// File: doc/lcd_spi_monitor.md
Name: lcd_spi_monitor

Overview:
Receive-side counterpart of the SPI LCD write path. Passively snoops the 4-wire LCD bus (SCL/CS/RS/SDA) driven by the LCD init/draw logic and deserialises it into command and data bytes. Tracks the CASET/RASET/RAMWR sequence and reconstructs RGB565 pixels with their (x, y) coordinates. Used for on-board loopback checking and for the UART debug dump.

Parameters:
SYNC_STAGES, 2, synchroniser depth on each of the four bus inputs (min 2)
COORD_W, 9, width of the column/row coordinates (extra high bits of CASET/RASET values are truncated)
H_RES, 240, column window after reset is 0..H_RES-1
V_RES, 240, row window after reset is 0..V_RES-1

Ports:
clk  input  1  system clock, 27 MHz
resetn  input  1  synchronous active-low reset
lcd_clk_i  input  1  snooped SCL; data sampled on its rising edge; period must be >= 4 clk
lcd_cs_i  input  1  snooped CS, active low
lcd_rs_i  input  1  snooped RS/DC: 0 = command, 1 = data
lcd_data_i  input  1  snooped SDA, MSB first
byte_valid  output  1  one-cycle strobe: a complete byte was received
byte_data  output  8  received byte, valid while byte_valid is high
byte_is_data  output  1  RS value sampled with bit 0 of the byte
pix_valid  output  1  one-cycle strobe: a pixel was completed
pix_data  output  16  RGB565 pixel {first byte, second byte}
pix_x  output  COORD_W  column of pix_data
pix_y  output  COORD_W  row of pix_data
frame_done  output  1  one-cycle strobe, coincident with pix_valid for the last pixel of the window
ramwr_active  output  1  high while the decoder is in the RAMWR state

Behaviour:
- Reset: every output is 0. Window is xs=0, xe=H_RES-1, ys=0, ye=V_RES-1. Decoder state is IDLE. Bit counter, pixel phase and x/y are cleared. Synchroniser flops are preset to idle levels: CS=1, SCL=0.
- Reset is sampled on clk only. Asserting it mid-byte or mid-frame discards all partial state on the next edge.
- Deserialiser:
  - SCL rising edge is detected from the synchronised SCL and its previous value.
  - On an edge with CS low, SDA is shifted into the shift register and the bit counter increments.
  - On the 8th bit: byte_valid pulses on the next clk, byte_is_data takes RS as sampled on that edge, and the bit counter returns to 0.
  - Latency is fixed at SYNC_STAGES+2 clk from the SCL rising pin edge to byte_valid.
  - Whenever CS is high, the bit counter is held at 0 and a partial byte is dropped silently. Decoder state, pixel phase and x/y are retained across CS deassertion.
- Decoder FSM, advanced only on byte_valid. States: IDLE, CASET, RASET, RAMWR.
  - Any command byte (is_data=0) aborts the current state, clears the parameter index and pixel phase, then dispatches:
    - 0x2A -> CASET
    - 0x2B -> RASET
    - 0x2C -> RAMWR, with x=xs, y=ys
    - any other value -> IDLE
  - CASET/RASET: collect 4 data bytes in order start_hi, start_lo, end_hi, end_lo.
    - On the 4th byte, xs/xe (or ys/ye) update atomically, truncated to COORD_W, and the state goes to IDLE.
    - If the sequence is aborted before the 4th byte, the window is unchanged.
  - IDLE: data bytes are ignored.
  - RAMWR, even data byte: latched as pix_data[15:8].
  - RAMWR, odd data byte: completes the pixel.
    - pix_valid pulses for one cycle with pix_data, pix_x=x, pix_y=y. This is one cycle after byte_valid, and pix outputs are held until the next pixel.
    - Then x advances by 1. At x==xe, x returns to xs and y advances.
    - At x==xe and y==ye: frame_done pulses with pix_valid, and x/y wrap to xs/ys. RAMWR continues.
  - Window with start > end: the end is treated as equal to the start (single column/row). The latched values are still reported as received.
- byte_valid and pix_valid never coincide for the same byte: pix_valid always lags its byte by one cycle.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C
  - the decoder state enum
  - default resolution constants, shared with the draw/init side
- One sub-module, lcd_spi_deser: input synchronisers, SCL edge detect, shift register and bit counter, producing byte_valid/byte_data/byte_is_data. The top level holds the decoder FSM and the coordinate counters.

Test Plan:
1. Reset with CS high, then SCL toggling -> no strobes. Send cmd 0x36 with RS=0 -> one byte_valid, byte_data=0x36, byte_is_data=0, state IDLE.
2. CASET 00 0A 00 0B, RASET 00 14 00 15, RAMWR, then 8 data bytes F8 00 07 E0 00 1F FF FF -> four pixels:
   - (10,20)=F800
   - (11,20)=07E0
   - (10,21)=001F
   - (11,21)=FFFF, with frame_done on this fourth pixel.
   Pixel 5 returns to (10,20).
3. CS raised after 5 bits of a byte, then a full byte 0xA5 -> exactly one byte_valid with 0xA5.
4. CASET 00 05 then cmd 0x2C -> window stays 0..239; the first pixel is at (0,0).
5. RAMWR, one data byte, CS high for 100 clk, then a second byte -> pixel completes with the correct 16-bit value.
6. resetn low for 1 clk mid-RAMWR after 3 bytes -> all outputs 0. Subsequent data bytes are ignored until a new 0x2C is sent.
